exec_step_controller: RTL

Execution sequencer for the single-cycle RISC-V core on the DE1-SoC, running entirely in the 50 MHz domain. It replaces the raw-button processor clock with a one-cycle `cpu_step` enable to the PC, register file and data memory. It supports three modes: debounced single-step, free-run at a selectable rate, and halt on PC breakpoint or EBREAK. It also exposes status (state, halt cause, retired-step count) to the LEDs and the VGA debug display.

---
 rtl/exec_ctrl_pkg.sv | 21 ++
 rtl/key_debouncer.sv | 53 +++++
 rtl/exec_step_controller.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/exec_ctrl_pkg.sv
// Shared types and constants for the execution step controller.
//   exec_state_t : sequencer mode (IDLE / RUN / HALT), encoded as on the status port
//   halt_cause_t : reason the sequencer stopped (NONE / BREAKPOINT / EBREAK)
//   EBREAK_INSN  : RV32I EBREAK encoding, checked against the fetched instruction
package exec_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } exec_state_t;

  typedef enum logic [1:0] {
    NONE       = 2'd0,
    BREAKPOINT = 2'd1,
    EBREAK     = 2'd2
  } halt_cause_t;

  localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;

endpackage

// File: rtl/key_debouncer.sv
// Two-flop synchronizer followed by a stable-level debouncer for one board input.
//   clk         : 50 MHz board clock
//   reset_n     : asynchronous active-low reset
//   raw         : asynchronous input (button or switch)
//   level       : accepted (debounced) level, reset to RESET_LEVEL
//   change      : high in the cycle whose closing edge flips 'level'; lets the
//                 consumer react on the same edge the new level is accepted
// A new level is accepted once the synchronized input has differed from the
// current level for CYCLES consecutive cycles.
module key_debouncer #(
  parameter int unsigned CYCLES      = 500000,
  parameter bit          RESET_LEVEL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic change
);

  localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  if (CYCLES < 1) begin : g_cycles_check
    $error("key_debouncer: CYCLES must be at least 1");
  end

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  assign change = (sync2 != level) && (cnt == CW'(CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= RESET_LEVEL;
      sync2 <= RESET_LEVEL;
      level <= RESET_LEVEL;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (change) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/exec_step_controller.sv
// Execution sequencer for the single-cycle RISC-V core (50 MHz domain).
// Produces a one-cycle cpu_step enable in single-step, free-run and halt modes.
//   clk, reset_n        : board clock, asynchronous active-low reset
//   step_key_n          : raw step button (active-low)
//   run_sw              : raw run switch (1 = run)
//   rate_sel            : run-rate select (DIV_SLOW / DIV_MED / DIV_FAST / DIV_MAX)
//   bp_enable, bp_addr  : PC breakpoint
//   pc_value            : current PC from the core
//   instruction         : current instruction word
//   cpu_step            : one-cycle commit enable to the core
//   state               : 0 IDLE, 1 RUN, 2 HALT
//   halt_cause          : 0 NONE, 1 BREAKPOINT, 2 EBREAK
//   step_count          : number of cpu_step pulses issued (wraps)
module exec_step_controller
  import exec_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned DIV_SLOW        = 50000000,
  parameter int unsigned DIV_MED         = 5000000,
  parameter int unsigned DIV_FAST        = 50000,
  parameter int unsigned DIV_MAX         = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        step_key_n,
  input  logic        run_sw,
  input  logic [1:0]  rate_sel,
  input  logic        bp_enable,
  input  logic [31:0] bp_addr,
  input  logic [31:0] pc_value,
  input  logic [31:0] instruction,
  output logic        cpu_step,
  output logic [1:0]  state,
  output logic [1:0]  halt_cause,
  output logic [31:0] step_count
);

  // Periods below 2 would allow back-to-back steps before the PC settles.
  if ((DIV_SLOW < 2) || (DIV_MED < 2) || (DIV_FAST < 2) || (DIV_MAX < 2)) begin : g_period_check
    $error("exec_step_controller: every step period must be at least 2");
  end

  logic step_level;
  logic step_change;
  logic run_level;
  logic run_change;

  key_debouncer #(
    .CYCLES      (DEBOUNCE_CYCLES),
    .RESET_LEVEL (1'b1)
  ) u_step_db (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (step_key_n),
    .level   (step_level),
    .change  (step_change)
  );

  key_debouncer #(
    .CYCLES      (DEBOUNCE_CYCLES),
    .RESET_LEVEL (1'b0)
  ) u_run_db (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (run_sw),
    .level   (run_level),
    .change  (run_change)
  );

  // press is the accepting edge of a debounced 1->0 transition, so the
  // registered cpu_step rises on the same edge the debounced key goes low.
  logic press;
  logic run_on;
  assign press  = step_change & step_level;
  assign run_on = run_level ^ run_change;

  exec_state_t st;
  halt_cause_t cause;
  logic        step_q;
  logic [31:0] count_q;
  logic [31:0] div_q;
  logic        skip_bp;

  logic [31:0] period_m1;
  always_comb begin
    period_m1 = DIV_SLOW - 1;
    case (rate_sel)
      2'd0:    period_m1 = DIV_SLOW - 1;
      2'd1:    period_m1 = DIV_MED  - 1;
      2'd2:    period_m1 = DIV_FAST - 1;
      default: period_m1 = DIV_MAX  - 1;
    endcase
  end

  logic div_done;
  logic is_ebreak;
  logic bp_hit;
  // '>=' so a shortened period after a rate change fires immediately.
  assign div_done  = (div_q >= period_m1);
  assign is_ebreak = (instruction == EBREAK_INSN);
  assign bp_hit    = bp_enable && (pc_value == bp_addr) && !skip_bp;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st      <= IDLE;
      cause   <= NONE;
      step_q  <= 1'b0;
      count_q <= '0;
      div_q   <= '0;
      skip_bp <= 1'b0;
    end else begin
      step_q <= 1'b0;
      if (step_q) begin
        count_q <= count_q + 32'd1;
      end
      unique case (st)
        IDLE: begin
          if (run_on) begin
            st      <= RUN;
            cause   <= NONE;
            div_q   <= '0;
            skip_bp <= 1'b1;
          end else if (press) begin
            step_q <= 1'b1;
          end
        end
        RUN: begin
          if (!run_on) begin
            st    <= IDLE;
            cause <= NONE;
          end else if (div_done) begin
            div_q <= '0;
            if (is_ebreak) begin
              st    <= HALT;
              cause <= EBREAK;
            end else if (bp_hit) begin
              st    <= HALT;
              cause <= BREAKPOINT;
            end else begin
              step_q  <= 1'b1;
              skip_bp <= 1'b0;
            end
          end else begin
            div_q <= div_q + 32'd1;
          end
        end
        HALT: begin
          if (!run_on) begin
            st    <= IDLE;
            cause <= NONE;
          end else if (press) begin
            step_q <= 1'b1;
          end
        end
        default: begin
          st <= IDLE;
        end
      endcase
    end
  end

  assign cpu_step   = step_q;
  assign state      = st;
  assign halt_cause = cause;
  assign step_count = count_q;

endmodule
